// File: rtl/m_axis_out_fifo.sv
// AXI4-Stream master output stage: buffers result beats (no backpressure on the input side)
// and drives a registered AXIS master interface, with occupancy status and frame tracking.
module m_axis_out_fifo #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_SIZE            = 16,
  parameter int unsigned ALMOST_FULL_MARGIN   = 2,
  localparam int unsigned bit_num             = $clog2(FIFO_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   in_data,
  input  logic                              in_last,
  input  logic                              axis_en,
  input  logic                              axis_clear,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [bit_num:0]                  fifo_cnt,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic                              almost_full,
  output logic                              overflow,
  output logic                              frame_done,
  output logic [15:0]                       frame_beat_cnt
);

  localparam int unsigned W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [bit_num:0]   FullCnt  = (bit_num + 1)'(FIFO_SIZE);
  localparam logic [bit_num:0]   AfThresh = (bit_num + 1)'(FIFO_SIZE - ALMOST_FULL_MARGIN);
  localparam logic [bit_num:0]   CntOne   = (bit_num + 1)'(1);
  localparam logic [bit_num-1:0] PtrOne   = bit_num'(1);

  logic [W:0]         mem_q [FIFO_SIZE];
  logic [bit_num-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [bit_num:0]   cnt_q, cnt_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [W-1:0]       tdata_q, tdata_d;
  logic               overflow_q, overflow_d, done_q, done_d;
  logic [15:0]        fbc_q, fbc_d;
  logic               push, pop, hs;

  assign fifo_full   = (cnt_q == FullCnt);
  assign fifo_empty  = (cnt_q == '0);
  assign almost_full = (cnt_q >= AfThresh);
  // A full array refuses a push even if a pop happens in the same cycle.
  assign push = in_valid && !fifo_full;
  assign hs   = tvalid_q && M_AXIS_TREADY;
  assign pop  = axis_en && !fifo_empty && (!tvalid_q || M_AXIS_TREADY);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    overflow_d = overflow_q;
    fbc_d      = fbc_q;
    done_d     = 1'b0;
    if (axis_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      tvalid_d   = 1'b0;
      tdata_d    = '0;
      tlast_d    = 1'b0;
      overflow_d = 1'b0;
      fbc_d      = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (in_valid && fifo_full) overflow_d = 1'b1;
      if (pop) begin
        rd_ptr_d             = rd_ptr_q + PtrOne;
        {tlast_d, tdata_d}   = mem_q[rd_ptr_q];
        tvalid_d             = 1'b1;
      end else if (hs) begin
        tvalid_d = 1'b0;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CntOne;
      end else if (!push && pop) begin
        cnt_d = cnt_q - CntOne;
      end
      if (hs) begin
        if (tlast_q) begin
          fbc_d  = '0;
          done_d = 1'b1;
        end else if (fbc_q != 16'hFFFF) begin
          fbc_d = fbc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !axis_clear) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
      fbc_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
      fbc_q      <= fbc_d;
      done_q     <= done_d;
    end
  end

  assign M_AXIS_TVALID  = tvalid_q;
  assign M_AXIS_TDATA   = tdata_q;
  assign M_AXIS_TLAST   = tlast_q;
  assign M_AXIS_TSTRB   = '1;
  assign fifo_cnt       = cnt_q;
  assign overflow       = overflow_q;
  assign frame_done     = done_q;
  assign frame_beat_cnt = fbc_q;

endmodule

// File: tb/tb_m_axis_out_fifo.sv
// Self-checking bench for m_axis_out_fifo: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_m_axis_out_fifo;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, axis_en, axis_clear, M_AXIS_TREADY;
  logic [31:0] in_data;
  logic        M_AXIS_TVALID, M_AXIS_TLAST;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic [4:0]  fifo_cnt;
  logic        fifo_full, fifo_empty, almost_full, overflow, frame_done;
  logic [15:0] frame_beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_axis_out_fifo #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .FIFO_SIZE(16),
    .ALMOST_FULL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .axis_en(axis_en), .axis_clear(axis_clear),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .overflow(overflow), .frame_done(frame_done),
    .frame_beat_cnt(frame_beat_cnt)
  );

  // Reference model: array contents as a queue plus the output register.
  logic [32:0] mq[$];
  logic        m_valid, m_last, m_ovf, m_done;
  logic [31:0] m_data;
  int          m_fbc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, iv, input logic [31:0] d,
                              input logic il, en, clr, rdy);
    logic hs, load, full;
    if (r || clr) begin
      mq.delete();
      m_valid = 0; m_data = 0; m_last = 0; m_ovf = 0; m_fbc = 0; m_done = 0;
    end else begin
      hs     = m_valid && rdy;
      load   = en && (mq.size() != 0) && (!m_valid || rdy);
      full   = (mq.size() == 16);
      m_done = hs && m_last;
      if (hs) m_fbc = m_last ? 0 : ((m_fbc == 65535) ? 65535 : m_fbc + 1);
      if (load) begin
        {m_last, m_data} = mq.pop_front();
        m_valid = 1;
      end else if (hs) begin
        m_valid = 0;
      end
      if (iv) begin
        if (full) m_ovf = 1;
        else mq.push_back({il, d});
      end
    end
  endtask

  task automatic compare_model();
    check("model tvalid", 32'(M_AXIS_TVALID), 32'(m_valid));
    if (m_valid) begin
      check("model tdata", M_AXIS_TDATA, m_data);
      check("model tlast", 32'(M_AXIS_TLAST), 32'(m_last));
    end
    check("model cnt", 32'(fifo_cnt), mq.size());
    check("model full", 32'(fifo_full), 32'(mq.size() == 16));
    check("model empty", 32'(fifo_empty), 32'(mq.size() == 0));
    check("model almost_full", 32'(almost_full), 32'(mq.size() >= 14));
    check("model overflow", 32'(overflow), 32'(m_ovf));
    check("model frame_done", 32'(frame_done), 32'(m_done));
    check("model frame_beat_cnt", 32'(frame_beat_cnt), m_fbc);
  endtask

  // Drive one cycle of inputs, clock, then compare against the model 1 time unit later.
  task automatic step(input logic r, iv, input logic [31:0] d, input logic il, en, clr, rdy);
    rst = r; in_valid = iv; in_data = d; in_last = il;
    axis_en = en; axis_clear = clr; M_AXIS_TREADY = rdy;
    @(posedge clk);
    model_update(r, iv, d, il, en, clr, rdy);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        r, iv;
    logic [31:0] d;
    logic        il, en, clr, rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    int          e_cnt;
    logic        e_done;
    int          e_fbc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int exp_cnt;
    logic [31:0] held;

    // Single-beat frame with the 2-cycle fill latency.
    tbl[0] = '{1, 0, 32'h0,          0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0};
    tbl[1] = '{0, 1, 32'hA5A5_0001,  1, 1, 0, 1, 0, 32'h0,          0, 1, 0, 0};
    tbl[2] = '{0, 0, 32'h0,          0, 1, 0, 1, 1, 32'hA5A5_0001,  1, 0, 0, 0};
    tbl[3] = '{0, 0, 32'h0,          0, 1, 0, 1, 0, 32'h0,          0, 0, 1, 0};
    tbl[4] = '{0, 0, 32'h0,          0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].il, tbl[i].en, tbl[i].clr, tbl[i].rdy);
      check($sformatf("vec%0d tvalid", i), 32'(M_AXIS_TVALID), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d tdata", i), M_AXIS_TDATA, tbl[i].e_data);
        check($sformatf("vec%0d tlast", i), 32'(M_AXIS_TLAST), 32'(tbl[i].e_last));
      end
      check($sformatf("vec%0d cnt", i), 32'(fifo_cnt), tbl[i].e_cnt);
      check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(tbl[i].e_done));
      check($sformatf("vec%0d frame_beat_cnt", i), 32'(frame_beat_cnt), tbl[i].e_fbc);
    end
    check("tstrb", 32'(M_AXIS_TSTRB), 32'hF);

    // Backpressure overflow: 20 beats with TREADY low.
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, i, 0, 1, 0, 0);
      exp_cnt = (i == 0) ? 1 : ((i > 16) ? 16 : i);
      check("ovf cnt", 32'(fifo_cnt), exp_cnt);
      check("ovf almost_full", 32'(almost_full), 32'(exp_cnt >= 14));
    end
    check("ovf held tdata", M_AXIS_TDATA, 0);
    check("ovf full", 32'(fifo_full), 1);
    check("ovf overflow", 32'(overflow), 1);
    for (int k = 0; k <= 16; k++) begin
      check("drain tvalid", 32'(M_AXIS_TVALID), 1);
      check("drain tdata", M_AXIS_TDATA, k);
      step(0, 0, 0, 0, 1, 0, 1);
    end
    check("drain end tvalid", 32'(M_AXIS_TVALID), 0);
    check("drain end empty", 32'(fifo_empty), 1);

    // Simultaneous push and pop at cnt=8 across the pointer wrap.
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 100 + i, 0, 1, 0, 0);
    check("pp start cnt", 32'(fifo_cnt), 8);
    for (int k = 0; k < 10; k++) begin
      check("pp tdata", M_AXIS_TDATA, 100 + k);
      step(0, 1, 109 + k, 0, 1, 0, 1);
      check("pp cnt", 32'(fifo_cnt), 8);
    end
    for (int k = 10; k < 19; k++) begin
      check("pp tail tdata", M_AXIS_TDATA, 100 + k);
      step(0, 0, 0, 0, 1, 0, 1);
    end

    // axis_en low holds the output register and blocks draining.
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'hBEEF_0000, 0, 1, 0, 0);
    step(0, 1, 32'hBEEF_0001, 0, 1, 0, 0);
    held = M_AXIS_TDATA;
    check("en hold first", held, 32'hBEEF_0000);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'hBEEF_0002 + k, 0, 0, 0, 0);
      check("en hold tvalid", 32'(M_AXIS_TVALID), 1);
      check("en hold tdata", M_AXIS_TDATA, held);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    check("en hs tvalid drop", 32'(M_AXIS_TVALID), 0);
    check("en hs cnt", 32'(fifo_cnt), 4);
    step(0, 0, 0, 0, 0, 0, 1);
    check("en no drain cnt", 32'(fifo_cnt), 4);
    step(0, 0, 0, 0, 1, 0, 0);
    check("en reload tdata", M_AXIS_TDATA, 32'hBEEF_0001);

    // axis_clear with cnt=5, TVALID=1, overflow=1 and a same-cycle beat.
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 1, 200 + i, 0, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1, 0, 1);
    check("clr pre cnt", 32'(fifo_cnt), 5);
    check("clr pre tvalid", 32'(M_AXIS_TVALID), 1);
    check("clr pre overflow", 32'(overflow), 1);
    step(0, 1, 32'hDEAD_BEEF, 1, 1, 1, 1);
    check("clr cnt", 32'(fifo_cnt), 0);
    check("clr tvalid", 32'(M_AXIS_TVALID), 0);
    check("clr overflow", 32'(overflow), 0);
    check("clr empty", 32'(fifo_empty), 1);
    step(0, 0, 0, 0, 1, 0, 1);
    check("clr dropped beat", 32'(fifo_cnt) + 32'(M_AXIS_TVALID), 0);

    // rst mid-burst with frame_beat_cnt=7, then 2-cycle latency on the first beat.
    step(1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 300 + i, 0, 1, 0, 1);
    check("rst pre fbc", 32'(frame_beat_cnt), 7);
    step(1, 1, 32'h1234, 0, 1, 0, 1);
    check("rst tvalid", 32'(M_AXIS_TVALID), 0);
    check("rst tdata", M_AXIS_TDATA, 0);
    check("rst tlast", 32'(M_AXIS_TLAST), 0);
    check("rst cnt", 32'(fifo_cnt), 0);
    check("rst empty", 32'(fifo_empty), 1);
    check("rst full", 32'(fifo_full), 0);
    check("rst almost_full", 32'(almost_full), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst fbc", 32'(frame_beat_cnt), 0);
    step(0, 1, 32'h5555_AAAA, 1, 1, 0, 0);
    check("post rst lat1 tvalid", 32'(M_AXIS_TVALID), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("post rst lat2 tvalid", 32'(M_AXIS_TVALID), 1);
    check("post rst lat2 tdata", M_AXIS_TDATA, 32'h5555_AAAA);

    // Randomized traffic in phases of differing downstream readiness.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 70, $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 99) < 85,
             $urandom_range(0, 199) == 0, $urandom_range(0, 99) < (ph * 30 + 10));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
